// File: rtl/sine_sched_pkg.sv
// Shared types and helpers for the round-robin quarter-wave sine ROM scheduler.
package sine_sched_pkg;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        neg;
  } fold_t;

  localparam logic [15:0] SAT16 = 16'hFFFF;

  // Quadrants 1 and 3 read the table mirrored; quadrants 2 and 3 negate.
  function automatic fold_t fold_addr(input logic [15:0] phase, input int unsigned addrw);
    fold_t       r;
    quadrant_t   q;
    logic [15:0] mask;
    mask = 16'((32'd1 << (addrw - 2)) - 32'd1);
    q    = quadrant_t'(2'(phase >> (addrw - 2)));
    r.addr = (q == Q1 || q == Q3) ? (mask & ~phase) : (mask & phase);
    r.neg  = (q == Q2) || (q == Q3);
    return r;
  endfunction

endpackage

// File: rtl/sine_rom_sched_arb.sv
// Round-robin arbiter: searches from pointer+1, pointer moves to the winner on en & |req.
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  int unsigned    idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req[IDW'(idx)]) begin
        found              = 1'b1;
        grant_id           = IDW'(idx);
        grant[IDW'(idx)]   = en;
      end
    end
    ptr_d = ptr_q;
    if (en && found) ptr_d = grant_id;
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= IDW'(N - 1);
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sine_rom_sched.sv
// Shares one async quarter-wave sine ROM among NREQ requesters via a 2-stage pipeline.
// Optional SINE_SCHED_STATS_EN adds saturating grant/stall counters.
module sine_rom_sched
  import sine_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned ROM_DEPTH = 64,
  parameter int unsigned ROM_WIDTH = 8,
  parameter int unsigned ADDRW     = $clog2(4 * ROM_DEPTH),
  parameter int unsigned IDW       = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ADDRW-1:0]     req_phase,
  output logic [$clog2(ROM_DEPTH)-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]      rom_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [2*ROM_WIDTH-1:0]    rsp_data
`ifdef SINE_SCHED_STATS_EN
  ,
  output logic [15:0]               stat_grants,
  output logic [15:0]               stat_stalls
`endif
);

  localparam int unsigned AW = $clog2(ROM_DEPTH);

  logic                   s1_valid_q, s1_valid_d;
  logic [ADDRW-1:0]       s1_phase_q, s1_phase_d;
  logic [IDW-1:0]         s1_id_q, s1_id_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [IDW-1:0]         s2_id_q, s2_id_d;
  logic [2*ROM_WIDTH-1:0] s2_data_q, s2_data_d;

  logic                   advance1, advance2, accept;
  logic [NREQ-1:0]        grant;
  logic [IDW-1:0]         grant_id;
  logic [ADDRW-1:0]       sel_phase;
  fold_t                  fold;
  logic [2*ROM_WIDTH-1:0] mag;

  assign advance2 = !s2_valid_q || rsp_ready;
  assign advance1 = !s1_valid_q || advance2;

  // Gating en with rst keeps req_ready low while reset is held.
  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (advance1 && rst),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  always_comb begin
    sel_phase = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_phase = req_phase[i*ADDRW +: ADDRW];
    end
  end

  assign fold     = fold_addr(16'(s1_phase_q), ADDRW);
  assign rom_addr = AW'(fold.addr);
  assign mag      = {{ROM_WIDTH{1'b0}}, rom_data};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_phase_d = s1_phase_q;
    s1_id_d    = s1_id_q;
    if (advance1) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_phase_d = sel_phase;
        s1_id_d    = grant_id;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_data_d  = s2_data_q;
    if (advance2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d   = s1_id_q;
        s2_data_d = fold.neg ? -mag : mag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_phase_q <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_phase_q <= s1_phase_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_id_q;
  assign rsp_data  = s2_data_q;

`ifdef SINE_SCHED_STATS_EN
  logic [15:0] stat_grants_q, stat_grants_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;

  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stalls_d = stat_stalls_q;
    if (accept && stat_grants_q != SAT16) stat_grants_d = stat_grants_q + 16'd1;
    if (s2_valid_q && !rsp_ready && stat_stalls_q != SAT16) stat_stalls_d = stat_stalls_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_sine_rom_sched.sv
// Directed self-checking bench for sine_rom_sched with a response scoreboard.
module tb_sine_rom_sched;

  localparam int NREQ = 4, ROM_DEPTH = 64, ROM_WIDTH = 8, ADDRW = 8, IDW = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDRW-1:0]  req_phase = '0;
  logic [5:0]             rom_addr;
  logic [ROM_WIDTH-1:0]   rom_data;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [IDW-1:0]         rsp_id;
  logic [2*ROM_WIDTH-1:0] rsp_data;
`ifdef SINE_SCHED_STATS_EN
  logic [15:0]            stat_grants, stat_stalls;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [5:0] a);
    return 8'({2'b00, a} * 8'd3 + 8'd5);
  endfunction

  assign rom_data = rom_val(rom_addr);

  sine_rom_sched #(
    .NREQ(NREQ), .ROM_DEPTH(ROM_DEPTH), .ROM_WIDTH(ROM_WIDTH), .ADDRW(ADDRW), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_phase(req_phase),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef SINE_SCHED_STATS_EN
    , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_phase(input int i, input int p);
    req_phase[i*ADDRW +: ADDRW] = 8'(p);
  endtask

  task automatic push(input int id, input int a, input bit neg);
    logic [15:0] m;
    m = {8'h00, rom_val(6'(a))};
    exp_q.push_back({2'(id), neg ? -m : m});
  endtask

  // Scoreboard: every transferred sample must match the next expected one.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e[17:16]));
          check("rsp_data", 32'(rsp_data), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ph[3] = '{74, 138, 202};
    int ad[3] = '{53, 10, 53};
    bit ng[3] = '{1'b0, 1'b1, 1'b1};
    int a4[4] = '{5, 57, 3, 0};
    bit n4[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    tick(); tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    req_valid = 4'hF;
    #1 check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst = 1'b1;
    tick();

    // Single request, latency
    set_phase(0, 10); req_valid = 4'b0001;
    #1 check("t1_req_ready", 32'(req_ready), 32'd1);
    push(0, 10, 1'b0);
    tick(); req_valid = '0;
    check("t1_rom_addr", 32'(rom_addr), 32'd10);
    check("t1_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", 32'(rsp_data), 32'd35);
    tick();
    check("t1_rsp_done", 32'(rsp_valid), 32'd0);

    // Quadrant folding, one requester granted every cycle
    for (int k = 0; k < 3; k++) begin
      set_phase(1, ph[k]); req_valid = 4'b0010;
      #1 check("t2_req_ready", 32'(req_ready), 32'd2);
      push(1, ad[k], ng[k]);
      tick();
      check("t2_rom_addr", 32'(rom_addr), 32'(ad[k]));
    end
    req_valid = '0;
    tick(); tick(); tick();
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Round robin across all requesters
    rst = 1'b0; tick(); rst = 1'b1;
    set_phase(0, 5); set_phase(1, 70); set_phase(2, 131); set_phase(3, 255);
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      #1 check("t3_req_ready", 32'(req_ready), 32'(1 << (k % 4)));
      push(k % 4, a4[k % 4], n4[k % 4]);
      tick();
      if (k >= 1) check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    req_valid = '0;
    tick();
    check("t3_rsp_last", 32'(rsp_valid), 32'd1);
    tick();
    check("t3_rsp_idle", 32'(rsp_valid), 32'd0);
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure with both stages full
    rsp_ready = 1'b0;
    set_phase(0, 10); req_valid = 4'b0001;
    #1 check("t4_req_ready0", 32'(req_ready), 32'd1);
    push(0, 10, 1'b0);
    tick();
    set_phase(1, 74); req_valid = 4'b0010;
    #1 check("t4_req_ready1", 32'(req_ready), 32'd2);
    push(1, 53, 1'b0);
    tick();
    set_phase(2, 202); req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1 check("t4_stall_ready", 32'(req_ready), 32'd0);
      check("t4_stall_valid", 32'(rsp_valid), 32'd1);
      check("t4_stall_id", 32'(rsp_id), 32'd0);
      check("t4_stall_data", 32'(rsp_data), 32'd35);
      check("t4_stall_addr", 32'(rom_addr), 32'd53);
      tick();
    end
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    check("t4_drain2_valid", 32'(rsp_valid), 32'd1);
    check("t4_drain2_id", 32'(rsp_id), 32'd1);
    tick();
    check("t4_drain_idle", 32'(rsp_valid), 32'd0);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // Reset while two samples are in flight
    rsp_ready = 1'b0;
    set_phase(2, 10); req_valid = 4'b0100;
    #1 check("t5_req_ready2", 32'(req_ready), 32'd4);
    tick();
    set_phase(3, 74); req_valid = 4'b1000;
    #1 check("t5_req_ready3", 32'(req_ready), 32'd8);
    tick();
    req_valid = '0;
    rst = 1'b0; exp_q.delete();
    tick();
    rst = 1'b1; rsp_ready = 1'b1;
    check("t5_rsp_after_rst", 32'(rsp_valid), 32'd0);
    req_valid = 4'hF;
    #1 check("t5_first_grant", 32'(req_ready), 32'd1);
    push(0, 10, 1'b0);
    tick(); req_valid = '0;
    check("t5_rsp_fill", 32'(rsp_valid), 32'd0);
    tick();
    check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    check("t5_drained", 32'(exp_q.size()), 32'd0);

`ifdef SINE_SCHED_STATS_EN
    rst = 1'b0; tick(); rst = 1'b1;
    check("st_rst_grants", 32'(stat_grants), 32'd0);
    check("st_rst_stalls", 32'(stat_stalls), 32'd0);
    set_phase(0, 10); req_valid = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      push(0, 10, 1'b0);
      tick();
    end
    req_valid = '0; rsp_ready = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("st_grants20", 32'(stat_grants), 32'd20);
    check("st_stalls5", 32'(stat_stalls), 32'd5);
    rsp_ready = 1'b1;
    tick(); tick(); tick();
    check("st_drained", 32'(exp_q.size()), 32'd0);
    req_valid = 4'b0001;
    for (int k = 0; k < 70000; k++) begin
      push(0, 10, 1'b0);
      tick();
    end
    req_valid = '0;
    check("st_grants_sat", 32'(stat_grants), 32'h0000FFFF);
    check("st_stalls_hold", 32'(stat_stalls), 32'd5);
    tick(); tick(); tick();
    check("st_drained2", 32'(exp_q.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
